// File: rtl/acc_pkg.sv
// acc_pkg: shared state encoding, job descriptor and default sizing for the accumulator pass scheduler
package acc_pkg;
    localparam int ACC_ADDR_W    = 10;
    localparam int ACC_DATA_W    = 32;
    localparam int ACC_PASS_W    = 8;
    localparam int ACC_FLUSH_CYC = 4;
    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, DRAIN, DONE} acc_sched_state_t;
    typedef struct packed {
        logic [ACC_ADDR_W-1:0] base;
        logic [ACC_ADDR_W:0]   len;
        logic [ACC_PASS_W-1:0] passes;
    } acc_job_t;
endpackage

// File: rtl/acc_pass_scheduler_if.sv
// acc_pass_scheduler_if: job, stream and accumulator-port signals of the pass scheduler
interface acc_pass_scheduler_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PASS_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] cfg_base;
    logic [ADDR_WIDTH:0]   cfg_len;
    logic [PASS_WIDTH-1:0] cfg_passes;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  acc_wr_en;
    logic                  acc_wr_we;
    logic [ADDR_WIDTH-1:0] acc_wr_addr;
    logic [DATA_WIDTH-1:0] acc_wr_wdata;
    logic                  acc_mode;
    logic                  acc_rd_en;
    logic [ADDR_WIDTH-1:0] acc_rd_addr;
    logic [DATA_WIDTH-1:0] acc_rd_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    modport master (
        input  start, cfg_base, cfg_len, cfg_passes, in_valid, in_data, acc_rd_rdata, out_ready,
        output in_ready, acc_wr_en, acc_wr_we, acc_wr_addr, acc_wr_wdata, acc_mode,
               acc_rd_en, acc_rd_addr, out_valid, out_data, out_last, busy, done
    );
    modport slave (
        output start, cfg_base, cfg_len, cfg_passes, in_valid, in_data, acc_rd_rdata, out_ready,
        input  in_ready, acc_wr_en, acc_wr_we, acc_wr_addr, acc_wr_wdata, acc_mode,
               acc_rd_en, acc_rd_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/acc_rd_skid.sv
// acc_rd_skid: 2-entry FIFO for drain read data, head reads as zero while empty
module acc_rd_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wp_q, wp_d, rp_q, rp_d;
    logic [1:0]   cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout  = (cnt_q != 2'd0) ? mem_q[rp_q] : '0;
    assign count = cnt_q;
endmodule

// File: rtl/acc_pass_scheduler.sv
// acc_pass_scheduler: multi-pass accumulate sequencer driving the accumulator write port, then draining results
module acc_pass_scheduler
    import acc_pkg::*;
#(
    parameter int ADDR_WIDTH = ACC_ADDR_W,
    parameter int DATA_WIDTH = ACC_DATA_W,
    parameter int PASS_WIDTH = ACC_PASS_W,
    parameter int FLUSH_CYC  = ACC_FLUSH_CYC
) (
    input logic                  clk,
    input logic                  rst,
    acc_pass_scheduler_if.master bus
);
    localparam logic [ADDR_WIDTH:0]   L1 = 1;
    localparam logic [PASS_WIDTH-1:0] P1 = 1;
    acc_sched_state_t        state_q, state_d;
    acc_job_t                job_q, job_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [PASS_WIDTH-1:0]   pass_q, pass_d;
    logic [7:0]              flush_q, flush_d;
    logic                    infl_q, infl_d, infl_last_q, infl_last_d;
    logic [1:0]              fifo_count;
    logic [DATA_WIDTH:0]     fifo_head;
    logic                    beat, idx_last, pass_last, issue, pop, out_valid;
    assign beat      = state_q == ACCUM && bus.in_valid;
    assign idx_last  = idx_q == job_q.len - L1;
    assign pass_last = pass_q == job_q.passes - P1;
    assign out_valid = fifo_count != 2'd0;
    assign pop       = out_valid && bus.out_ready;
    // Credit counts the slot freed by this cycle's pop so back-to-back reads sustain one word per cycle
    assign issue     = state_q == DRAIN && idx_q != job_q.len &&
                       ({1'b0, fifo_count} + {2'b0, infl_q} - {2'b0, pop}) < 3'd2;
    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        flush_d     = flush_q;
        infl_d      = issue;
        infl_last_d = idx_last;
        unique case (state_q)
            IDLE: if (bus.start) begin
                job_d   = '{base: bus.cfg_base, len: bus.cfg_len, passes: bus.cfg_passes};
                idx_d   = '0;
                pass_d  = '0;
                state_d = (bus.cfg_len == '0 || bus.cfg_passes == '0) ? DONE : ACCUM;
            end
            ACCUM: if (beat) begin
                idx_d   = idx_last ? '0 : idx_q + L1;
                pass_d  = idx_last ? pass_q + P1 : pass_q;
                state_d = (idx_last && pass_last) ? FLUSH : ACCUM;
                flush_d = '0;
            end
            FLUSH: begin
                flush_d = flush_q + 8'd1;
                state_d = (flush_q == 8'(FLUSH_CYC - 1)) ? DRAIN : FLUSH;
            end
            DRAIN: begin
                idx_d   = issue ? idx_q + L1 : idx_q;
                state_d = (pop && fifo_head[DATA_WIDTH]) ? DONE : DRAIN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            job_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            flush_q     <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            flush_q     <= flush_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end
    acc_rd_skid #(.W(DATA_WIDTH + 1)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (infl_q),
        .din   ({infl_last_q, bus.acc_rd_rdata}),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count)
    );
    assign bus.in_ready     = state_q == ACCUM;
    assign bus.acc_wr_en    = beat;
    assign bus.acc_wr_we    = beat;
    assign bus.acc_wr_addr  = beat ? job_q.base + idx_q[ADDR_WIDTH-1:0] : '0;
    assign bus.acc_wr_wdata = beat ? bus.in_data : '0;
    assign bus.acc_mode     = beat && pass_q != '0;
    assign bus.acc_rd_en    = issue;
    assign bus.acc_rd_addr  = issue ? job_q.base + idx_q[ADDR_WIDTH-1:0] : '0;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = fifo_head[DATA_WIDTH-1:0];
    assign bus.out_last     = fifo_head[DATA_WIDTH];
    assign bus.busy         = state_q != IDLE && state_q != DONE;
    assign bus.done         = state_q == DONE;
endmodule
